// File: rtl/adc_sample_ctrl.sv
// Periodic ADC sampler feeding a show-ahead FIFO; optional ADC_SAMPLE_AVG_EN averages two conversions per period.
// Latency adc_ready->rd_data is 2 cycles; a full FIFO that is not popped drops the sample and sets overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     head_vld,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign head_vld = (level != '0);
  assign do_pop   = pop && head_vld;
  // A pop frees the slot the same cycle, so a full FIFO can still take a write.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        level <= level + LW'(1);
      else if (!do_push && do_pop)
        level <= level - LW'(1);
    end
  end
endmodule

module adc_sample_ctrl #(
  parameter int PERIOD  = 1000,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   adc_convert,
  input  logic                   adc_ready,
  input  logic [7:0]             adc_q,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   timeout_err,
  input  logic                   clr_err
);
  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, WAIT, CAPTURE} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic          period_hit;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    sample;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          ovf_set;

`ifdef ADC_SAMPLE_AVG_EN
  logic       second;
  logic [7:0] first_q;
  logic [8:0] sum;
  assign sum = {1'b0, first_q} + {1'b0, adc_q} + 9'd1;
`endif

  assign period_hit = (period_cnt == PW'(PERIOD - 1));
  assign push       = (state == CAPTURE);
  assign pop        = rd_valid && rd_ready;
  assign ovf_set    = push && fifo_full && !pop;

  // Free-running pacing counter; hits while busy are simply lost.
  always_ff @(posedge clk) begin
    if (reset || !enable)
      period_cnt <= '0;
    else if (period_hit)
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      adc_convert <= 1'b0;
      tmo_cnt     <= '0;
      sample      <= '0;
      timeout_err <= 1'b0;
`ifdef ADC_SAMPLE_AVG_EN
      second      <= 1'b0;
      first_q     <= '0;
`endif
    end else begin
      adc_convert <= 1'b0;
      if (clr_err) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && period_hit) begin
            state       <= CONVERT;
            adc_convert <= 1'b1;
          end
        end
        CONVERT: begin
          tmo_cnt <= TW'(TIMEOUT);
          state   <= WAIT;
        end
        WAIT: begin
          if (adc_ready) begin
`ifdef ADC_SAMPLE_AVG_EN
            if (!second) begin
              first_q     <= adc_q;
              second      <= 1'b1;
              state       <= CONVERT;
              adc_convert <= 1'b1;
            end else begin
              sample <= 8'(sum >> 1);
              second <= 1'b0;
              state  <= CAPTURE;
            end
`else
            sample <= adc_q;
            state  <= CAPTURE;
`endif
          end else if (tmo_cnt <= TW'(1)) begin
            // Counter would reach zero now: give up; a set beats a same-cycle clear.
            timeout_err <= 1'b1;
            state       <= IDLE;
`ifdef ADC_SAMPLE_AVG_EN
            second      <= 1'b0;
`endif
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (ovf_set)
      overflow <= 1'b1;
    else if (clr_err)
      overflow <= 1'b0;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (sample),
    .pop      (rd_ready),
    .head_dat (rd_data),
    .head_vld (rd_valid),
    .level    (fifo_level),
    .full     (fifo_full)
  );
endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl (PERIOD=16, DEPTH=8, TIMEOUT=255) with a simple ADC responder.
module tb_adc_sample_ctrl;
  logic       clk = 1'b0;
  logic       reset, enable, adc_ready, rd_ready, clr_err;
  logic [7:0] adc_q;
  logic       adc_convert, rd_valid, overflow, timeout_err;
  logic [7:0] rd_data;
  logic [3:0] fifo_level;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_delay = 3;
  int pending = 0;
  logic [7:0] model_q = 8'h00;
  logic [7:0] model_step = 8'h00;

  adc_sample_ctrl #(.PERIOD(16), .DEPTH(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_convert(adc_convert),
    .adc_ready(adc_ready), .adc_q(adc_q), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .fifo_level(fifo_level), .overflow(overflow),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // ADC model: raises adc_ready for one cycle model_delay cycles after a convert pulse.
  initial begin
    adc_ready = 1'b0;
    adc_q = 8'h00;
    forever begin
      @(posedge clk); #1;
      adc_ready = 1'b0;
      if (pending == 0) begin
        if (adc_convert && model_delay > 0) pending = model_delay;
      end else begin
        pending--;
        if (pending == 0) begin
          adc_ready = 1'b1;
          adc_q = model_q;
          model_q = model_q + model_step;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic restart();
    reset = 1'b1; enable = 1'b1; clr_err = 1'b0; rd_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clr_err = 1'b0; rd_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (adc_convert !== 1'b0) begin n_fail++; $display("FAIL reset_convert got=%b exp=0", adc_convert); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rd_data); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
  endtask

`ifdef ADC_SAMPLE_AVG_EN
  task automatic test_average();
    restart();
    model_delay = 3; model_q = 8'h10; model_step = 8'h03;
    for (int c = 1; c <= 30; c++) begin
      goto_cyc(c);
      n_checks++;
      if (adc_convert !== (c == 16 || c == 20)) begin
        n_fail++; $display("FAIL avg_convert cyc=%0d got=%b", c, adc_convert);
      end
      n_checks++;
      if (rd_valid !== (c >= 25)) begin
        n_fail++; $display("FAIL avg_valid cyc=%0d got=%b", c, rd_valid);
      end
    end
    n_checks++; if (rd_data !== 8'h12) begin n_fail++; $display("FAIL avg_data got=%h exp=12", rd_data); end
    n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL avg_level got=%0d exp=1", fifo_level); end
    enable = 1'b0;
  endtask
`else
  task automatic test_basic();
    restart();
    rd_ready = 1'b1; model_delay = 3; model_q = 8'h5A; model_step = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      goto_cyc(c);
      n_checks++;
      if (adc_convert !== (c == 16 || c == 32)) begin
        n_fail++; $display("FAIL basic_convert cyc=%0d got=%b", c, adc_convert);
      end
      n_checks++;
      if (rd_valid !== (c == 21 || c == 37)) begin
        n_fail++; $display("FAIL basic_valid cyc=%0d got=%b", c, rd_valid);
      end
      if (c == 21 || c == 37) begin
        n_checks++;
        if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL basic_data cyc=%0d got=%h exp=5a", c, rd_data); end
      end
      n_checks++;
      if (fifo_level > 4'd1) begin n_fail++; $display("FAIL basic_level cyc=%0d got=%0d max=1", c, fifo_level); end
    end
  endtask

  task automatic fill_fifo();
    restart();
    model_delay = 3; model_q = 8'h01; model_step = 8'h01;
    goto_cyc(133);
  endtask

  task automatic test_overflow();
    fill_fifo();
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level8 got=%0d exp=8", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    goto_cyc(148);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_capture got=%b exp=0", overflow); end
    goto_cyc(149);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
    goto_cyc(166);
    enable = 1'b0;
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_drain idx=%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(i));
      end
      goto_cyc(cyc + 1);
    end
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", rd_valid, fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_err = 1'b1;
    goto_cyc(cyc + 1);
    clr_err = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pop();
    fill_fifo();
    goto_cyc(148);
    rd_ready = 1'b1;
    goto_cyc(149);
    rd_ready = 1'b0;
    enable = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got=%b exp=0", overflow); end
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fullpop_level got=%0d exp=8", fifo_level); end
    rd_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        n_fail++; $display("FAIL fullpop_drain idx=%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(i));
      end
      goto_cyc(cyc + 1);
    end
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty got=%b exp=0", rd_valid); end
  endtask

  task automatic test_timeout();
    restart();
    rd_ready = 1'b1; model_delay = -1;
    goto_cyc(16);
    n_checks++; if (adc_convert !== 1'b1) begin n_fail++; $display("FAIL tmo_convert got=%b exp=1", adc_convert); end
    for (int c = 17; c <= 271; c++) begin
      goto_cyc(c);
      n_checks++;
      if (adc_convert !== 1'b0) begin n_fail++; $display("FAIL tmo_overrun cyc=%0d got=%b exp=0", c, adc_convert); end
    end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early got=%b exp=0", timeout_err); end
    goto_cyc(272);
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set got=%b exp=1", timeout_err); end
    n_checks++; if (fifo_level !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_nowrite got=%0d/%b exp=0/0", fifo_level, rd_valid); end
    clr_err = 1'b1;
    goto_cyc(273);
    clr_err = 1'b0;
    enable = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
  endtask

  task automatic test_timeout_edge();
    restart();
    rd_ready = 1'b0; model_delay = 255; model_q = 8'hC3; model_step = 8'h00;
    goto_cyc(272);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL edge_early got=%b exp=0", rd_valid); end
    goto_cyc(273);
    enable = 1'b0;
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin n_fail++; $display("FAIL edge_sample got=%b/%h exp=1/c3", rd_valid, rd_data); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL edge_timeout got=%b exp=0", timeout_err); end
  endtask

  task automatic test_reset_mid_wait();
    restart();
    model_delay = 3; model_q = 8'h21; model_step = 8'h01;
    goto_cyc(53);
    n_checks++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL rstw_level3 got=%0d exp=3", fifo_level); end
    model_delay = 10;
    goto_cyc(66);
    reset = 1'b1;
    goto_cyc(67);
    reset = 1'b0;
    n_checks++; if (adc_convert !== 1'b0) begin n_fail++; $display("FAIL rstw_convert got=%b exp=0", adc_convert); end
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL rstw_rd got=%b/%h exp=0/00", rd_valid, rd_data); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rstw_level got=%0d exp=0", fifo_level); end
    n_checks++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstw_flags got=%b/%b exp=0/0", overflow, timeout_err); end
    goto_cyc(80);
    enable = 1'b0;
    n_checks++; if (fifo_level !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_late got=%0d/%b exp=0/0", fifo_level, rd_valid); end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; rd_ready = 1'b0; clr_err = 1'b0;
    test_reset();
`ifdef ADC_SAMPLE_AVG_EN
    test_average();
`else
    test_basic();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Periodic ADC sampling controller that sits directly upstream of the chip's I2C register/readout logic. It paces conversions by issuing `adc_convert` pulses and waiting for `adc_ready`, then captures `adc_q`. Captured samples are buffered in a small show-ahead FIFO, which the readout stage drains through a valid/ready handshake. It also reports overflow and conversion-timeout errors as sticky flags.

## Interface
- `PERIOD`, 1000: clock cycles between conversion starts; legal range ≥ 16.
- `DEPTH`, 8: FIFO entries; power of 2, ≥ 2.
- `TIMEOUT`, 255: maximum cycles spent waiting for `adc_ready` after a convert pulse.
- `clk`  in  1  chip clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  sampling enable; when low, no new conversions start.
- `adc_convert`  out  1  one-cycle conversion start pulse to the ADC.
- `adc_ready`  in  1  ADC result valid; `adc_q` is sampled on the same cycle.
- `adc_q`  in  8  ADC result.
- `rd_data`  out  8  FIFO head (show-ahead).
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer accepts `rd_data`; a pop occurs when `rd_valid & rd_ready`.
- `fifo_level`  out  $clog2(DEPTH)+1  current entry count.
- `overflow`  out  1  sticky: a sample was dropped.
- `timeout_err`  out  1  sticky: `adc_ready` did not arrive in time.
- `clr_err`  in  1  clears both sticky flags.

## Operation
- **FSM states:** IDLE, CONVERT, WAIT, CAPTURE.
- **Period counter:** free-runs 0..PERIOD-1 while `enable`=1. It is held at 0 while `enable`=0.
- **IDLE → CONVERT:** when the counter equals PERIOD-1 and `enable`=1.
- **CONVERT:**
  - `adc_convert`=1 for exactly this one cycle.
  - Loads the timeout counter with TIMEOUT.
  - Always goes to WAIT.
- **WAIT:**
  - On `adc_ready`=1: latch `adc_q` and go to CAPTURE.
  - Otherwise decrement the timeout counter. At 0, set `timeout_err` and return to IDLE; no FIFO write occurs.
  - If `adc_ready` arrives on the same cycle the counter reaches 0, the sample wins and no timeout is flagged.
- **CAPTURE:**
  - Writes the latched sample to the FIFO, then goes to IDLE.
  - If the FIFO is full and no pop occurs this cycle, the sample is dropped and `overflow` is set.
  - If the FIFO is full and a pop occurs this cycle, the write is accepted and `fifo_level` stays at DEPTH.
- **`adc_ready` outside WAIT:** ignored.
- **`enable` falling mid-conversion:** the current conversion completes through CAPTURE or timeout. No further conversions start.
- **Period overrun:** the period counter keeps running during WAIT/CAPTURE. If it hits PERIOD-1 while the FSM is not in IDLE, that trigger is skipped (no queuing).
- **Sticky flags:**
  - `clr_err` clears both flags.
  - A set event on the same cycle as `clr_err` wins, so the flag stays 1.
- **FIFO pointers:** wrap modulo DEPTH. A pop when empty is ignored.

## Timing
- **Reset values:** all outputs 0 (`adc_convert`, `rd_data`, `rd_valid`, `fifo_level`, `overflow`, `timeout_err`). FSM=IDLE, period counter=0, FIFO empty.
- **First conversion:** with `enable` high from cycle 0 after reset release, the first `adc_convert` pulse is at cycle PERIOD, and then every PERIOD cycles.
- **Sample-to-output latency:** `adc_ready` sampled at cycle N → CAPTURE at N+1 → `rd_valid`/`rd_data` updated at N+2.
- **Pop latency:** pop at cycle M → the next head entry (or `rd_valid`=0) is visible at M+1.
- **Minimum convert-to-convert spacing:** PERIOD cycles.
- **Reset mid-operation:** the FSM returns to IDLE immediately, the FIFO is flushed, and the flags are cleared. An in-flight `adc_ready` is ignored.

## Configuration
- **Macro:** `ADC_SAMPLE_AVG_EN`.
- **Defined:** each period performs two back-to-back conversions.
  - The FSM is CONVERT→WAIT→CONVERT→WAIT→CAPTURE.
  - The value written to the FIFO is the rounded mean `(a + b + 1) >> 1`, computed with a 9-bit intermediate.
  - A timeout on either conversion aborts the pair and sets `timeout_err`; no write occurs.
  - The second `adc_convert` is issued on the cycle after the first `adc_ready`.
- **Undefined:** a single conversion per period with a raw sample write, as described above.

## Test plan
- **Basic capture:** PERIOD=16, ADC model returns 0x5A with `adc_ready` 3 cycles after each convert, `rd_ready`=1 → `adc_convert` pulses at cycles 16, 32, …; `rd_data`=0x5A with `rd_valid` 2 cycles after each `adc_ready`; `fifo_level` never exceeds 1.
- **Overflow:** `rd_ready`=0, DEPTH=8, samples 0x01..0x0A → `fifo_level`=8, `overflow`=1 after the 9th sample; draining yields 0x01..0x08 in order.
- **Full with simultaneous pop:** FIFO full, `rd_ready`=1 on the CAPTURE cycle → `overflow` stays 0, `fifo_level` stays 8, and the new sample appears last.
- **Timeout:** `adc_ready` never asserted, TIMEOUT=255 → `timeout_err`=1 at 256 cycles after the convert pulse, no FIFO write; a later `clr_err` pulse → 0.
- **Reset mid-WAIT:** `reset` asserted during WAIT with 3 entries queued → next cycle all outputs are 0 and a late `adc_ready` produces no write.
- **Averaging (`ADC_SAMPLE_AVG_EN` defined):** ADC returns 0x10 then 0x13 → a single FIFO entry of 0x12; two `adc_convert` pulses per period.
